// File: rtl/snd_sequencer.sv
// -----------------------------------------------------------------------------
// snd_sequencer
//
// Note sequencer for the I2S audio path. A small writable note table is stepped
// through once started. For each entry the sequencer drives the sound generator's
// volume and period for dur * TICKS_PER_UNIT frame ticks, then moves to the next
// entry, loops back to entry 0, or finishes.
//
// Table entry layout (25 bits):
//   [24] end   last note of the sequence
//   [23:16] dur  duration in units; 0 marks a stop entry
//   [15:12] vol  volume
//   [11:0]  period
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   wr_en        note table write strobe
//   wr_addr      note table write address
//   wr_data      note table write data
//   start        pulse: (re)start playback at entry 0
//   stop         pulse: abort playback and silence (wins over start)
//   loop_en      level: restart at entry 0 at an end condition
//   tick         one pulse per audio frame
//   snd_vol      volume to the sound generator
//   snd_period   period to the sound generator
//   busy         high while not idle
//   note_idx     index of the note currently applied
//   note_strobe  one-cycle pulse when a new note is applied
//   done         one-cycle pulse on natural completion
// -----------------------------------------------------------------------------
module snd_sequencer #(
  parameter int ADDR_W         = 4,
  parameter int TICKS_PER_UNIT = 122
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [24:0]       wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              tick,
  output logic [3:0]        snd_vol,
  output logic [11:0]       snd_period,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              note_strobe,
  output logic              done
);

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_idx,       w_idx_nxt;
  logic [7:0]        r_dur_rem,   w_dur_rem_nxt;
  logic [15:0]       r_presc,     w_presc_nxt;
  logic              r_end,       w_end_nxt;
  logic [3:0]        r_vol,       w_vol_nxt;
  logic [11:0]       r_period,    w_period_nxt;
  logic [ADDR_W-1:0] r_note_idx,  w_note_idx_nxt;
  logic              r_strobe,    w_strobe_nxt;
  logic              r_done,      w_done_nxt;

  logic [24:0]       r_mem [DEPTH];
  logic [24:0]       r_rd_data;

  logic              w_rd_end;
  logic [7:0]        w_rd_dur;
  logic [3:0]        w_rd_vol;
  logic [11:0]       w_rd_period;

  assign w_rd_end    = r_rd_data[24];
  assign w_rd_dur    = r_rd_data[23:16];
  assign w_rd_vol    = r_rd_data[15:12];
  assign w_rd_period = r_rd_data[11:0];

  // NOTE: the table and its read register carry no reset -- RAM contents are
  // undefined until written, and a reset here would prevent RAM inference.
  // The read register samples r_idx every cycle; its value is only consumed in
  // LOAD, one cycle after FETCH presented the index. A same-address write in
  // that cycle returns the old word because the array updates after the read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[r_idx];
  end

  // NOTE: every next-value signal gets its hold/idle default before the case
  // statement, so no path through this block leaves a signal unassigned and
  // no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_dur_rem_nxt  = r_dur_rem;
    w_presc_nxt    = r_presc;
    w_end_nxt      = r_end;
    w_vol_nxt      = r_vol;
    w_period_nxt   = r_period;
    w_note_idx_nxt = r_note_idx;
    w_strobe_nxt   = 1'b0;
    w_done_nxt     = 1'b0;

    if (stop) begin
      // Abort: silence but keep period and note index for inspection.
      w_state_nxt = S_IDLE;
      w_vol_nxt   = 4'd0;
    end else if (start) begin
      // Start or restart from entry 0 regardless of the current state.
      w_state_nxt = S_FETCH;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end

        S_FETCH: begin
          w_state_nxt = S_LOAD;
        end

        S_LOAD: begin
          if (w_rd_dur != 8'd0) begin
            w_vol_nxt      = w_rd_vol;
            w_period_nxt   = w_rd_period;
            w_note_idx_nxt = r_idx;
            w_dur_rem_nxt  = w_rd_dur;
            w_end_nxt      = w_rd_end;
            w_presc_nxt    = 16'd0;
            w_strobe_nxt   = 1'b1;
            w_state_nxt    = S_PLAY;
          end else if (loop_en && (r_idx != '0)) begin
            // Stop marker while looping: back to the top. Excluding idx 0
            // keeps a stop marker in entry 0 from spinning forever.
            w_idx_nxt   = '0;
            w_state_nxt = S_FETCH;
          end else begin
            w_vol_nxt   = 4'd0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end

        S_PLAY: begin
          if (tick) begin
            if (r_presc == PRESC_LAST) begin
              w_presc_nxt = 16'd0;
              if (r_dur_rem == 8'd1) begin
                if (!r_end) begin
                  w_idx_nxt   = r_idx + 1'b1;  // wraps at the table size
                  w_state_nxt = S_FETCH;
                end else if (loop_en) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_FETCH;
                end else begin
                  w_vol_nxt   = 4'd0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
                end
              end else begin
                w_dur_rem_nxt = r_dur_rem - 8'd1;
              end
            end else begin
              w_presc_nxt = r_presc + 16'd1;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_dur_rem  <= 8'd0;
      r_presc    <= 16'd0;
      r_end      <= 1'b0;
      r_vol      <= 4'd0;
      r_period   <= 12'd0;
      r_note_idx <= '0;
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_dur_rem  <= w_dur_rem_nxt;
      r_presc    <= w_presc_nxt;
      r_end      <= w_end_nxt;
      r_vol      <= w_vol_nxt;
      r_period   <= w_period_nxt;
      r_note_idx <= w_note_idx_nxt;
      r_strobe   <= w_strobe_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign snd_vol     = r_vol;
  assign snd_period  = r_period;
  assign busy        = (r_state != S_IDLE);
  assign note_idx    = r_note_idx;
  assign note_strobe = r_strobe;
  assign done        = r_done;

endmodule

// File: tb/tb_snd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snd_sequencer
//
// Self-checking bench for snd_sequencer with ADDR_W=2, TICKS_PER_UNIT=4 and a
// frame tick every 8 clocks. A reference model walks the note table by the
// sequencing rules and produces the expected list of events (notes with their
// index/volume/period/length in ticks, and completion). The checker waits for
// each event, compares outputs, and measures note lengths in sampled ticks.
// -----------------------------------------------------------------------------
module tb_snd_sequencer;

  localparam int ADDR_W = 2;
  localparam int NENT   = 1 << ADDR_W;
  localparam int TPU    = 4;
  localparam int BUDGET = 300;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [24:0]       wr_data;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              tick;
  logic [3:0]        snd_vol;
  logic [11:0]       snd_period;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              note_strobe;
  logic              done;

  snd_sequencer #(
    .ADDR_W        (ADDR_W),
    .TICKS_PER_UNIT(TPU)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .tick       (tick),
    .snd_vol    (snd_vol),
    .snd_period (snd_period),
    .busy       (busy),
    .note_idx   (note_idx),
    .note_strobe(note_strobe),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ticks actually presented to the DUT at a rising edge.
  int tick_seen = 0;
  always_ff @(posedge clk) begin
    if (tick) tick_seen <= tick_seen + 1;
  end

  typedef struct {
    bit is_done;
    int idx;
    int vol;
    int period;
    int ticks;
  } ev_t;

  ev_t         exp_q[$];
  logic [24:0] tab [NENT];

  int n_pass  = 0;
  int n_total = 0;
  int tph     = 0;

  // Tracking of what the outputs must currently show.
  bit have_prev   = 0;
  int prev_mark   = 0;
  int prev_ticks  = 0;
  bit cur_valid   = 0;
  int cur_vol     = 0;
  int cur_period  = 0;
  int exp_period  = 0;
  int exp_nidx    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Advance to the next falling edge; the frame tick is driven here so that it
  // keeps a fixed 8-clock period across every stimulus step.
  task automatic step();
    @(negedge clk);
    tph  = (tph + 1) % 8;
    tick = (tph == 0);
  endtask

  function automatic logic [24:0] ent(input int e, input int d, input int v, input int p);
    logic [7:0]  d8;
    logic [3:0]  v4;
    logic [11:0] p12;
    d8  = d[7:0];
    v4  = v[3:0];
    p12 = p[11:0];
    return {e[0], d8, v4, p12};
  endfunction

  task automatic wr(input int a, input logic [24:0] d);
    wr_en   = 1'b1;
    wr_addr = a[ADDR_W-1:0];
    wr_data = d;
    tab[a]  = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Reference model: walk the table from sidx and list up to maxev notes,
  // followed by completion if the sequence finishes.
  function automatic void build(input bit lp, input int sidx, input int maxev);
    int   idx;
    int   guard;
    int   dur;
    bit   last;
    ev_t  ev;
    exp_q.delete();
    idx   = sidx;
    guard = 0;
    while (guard < 64) begin
      guard++;
      dur  = int'(tab[idx][23:16]);
      last = tab[idx][24];
      if (dur == 0) begin
        if (lp && idx != 0) begin
          idx = 0;
          continue;
        end
        ev = '{is_done: 1'b1, idx: 0, vol: 0, period: 0, ticks: 0};
        exp_q.push_back(ev);
        break;
      end
      ev = '{is_done: 1'b0, idx: idx, vol: int'(tab[idx][15:12]),
             period: int'(tab[idx][11:0]), ticks: dur * TPU};
      exp_q.push_back(ev);
      if (exp_q.size() >= maxev) break;
      if (!last) idx = (idx + 1) % NENT;
      else if (lp) idx = 0;
      else begin
        ev = '{is_done: 1'b1, idx: 0, vol: 0, period: 0, ticks: 0};
        exp_q.push_back(ev);
        break;
      end
    end
  endfunction

  // Consume the expected events in order, checking outputs at each one.
  task automatic play_check();
    ev_t ev;
    int  cyc;
    while (exp_q.size() > 0) begin
      ev  = exp_q.pop_front();
      cyc = 0;
      while (!(note_strobe || done) && cyc < BUDGET) begin
        if (cur_valid) begin
          chk("held_vol", 32'(snd_vol), cur_vol);
          chk("held_period", 32'(snd_period), cur_period);
        end
        step();
        cyc++;
      end
      if (cyc >= BUDGET) begin
        chk("event_timeout", 32'(note_strobe | done), 1);
        exp_q.delete();
        return;
      end
      if (have_prev) chk("note_ticks", tick_seen - prev_mark, prev_ticks);
      if (ev.is_done) begin
        chk("done_seen", 32'(done), 1);
        chk("strobe_at_done", 32'(note_strobe), 0);
        chk("vol_at_done", 32'(snd_vol), 0);
        chk("busy_at_done", 32'(busy), 0);
        have_prev = 0;
        cur_valid = 0;
      end else begin
        chk("strobe_seen", 32'(note_strobe), 1);
        chk("done_at_note", 32'(done), 0);
        chk("note_idx", 32'(note_idx), ev.idx);
        chk("note_vol", 32'(snd_vol), ev.vol);
        chk("note_period", 32'(snd_period), ev.period);
        chk("busy_at_note", 32'(busy), 1);
        have_prev  = 1;
        prev_mark  = tick_seen;
        prev_ticks = ev.ticks;
        cur_valid  = 1;
        cur_vol    = ev.vol;
        cur_period = ev.period;
        exp_period = ev.period;
        exp_nidx   = ev.idx;
      end
      step();
      chk("strobe_one_cycle", 32'(note_strobe), 0);
      chk("done_one_cycle", 32'(done), 0);
    end
  endtask

  task automatic do_start();
    have_prev = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop(input bit with_start);
    stop  = 1'b1;
    start = with_start;
    step();
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_vol", 32'(snd_vol), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_done", 32'(done), 0);
    chk("stop_period_held", 32'(snd_period), exp_period);
    chk("stop_idx_held", 32'(note_idx), exp_nidx);
    cur_valid = 0;
    have_prev = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stop_no_done", 32'(done), 0);
      chk("stop_stays_idle", 32'(busy), 0);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_vol"}, 32'(snd_vol), 0);
    chk({tag, "_period"}, 32'(snd_period), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_idx"}, 32'(note_idx), 0);
    chk({tag, "_strobe"}, 32'(note_strobe), 0);
    chk({tag, "_done"}, 32'(done), 0);
    have_prev  = 0;
    cur_valid  = 0;
    exp_period = 0;
    exp_nidx   = 0;
  endtask

  initial begin
    int lp;

    reset_n = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    tick    = 1'b0;

    // Power-on reset.
    #2 reset_n = 1'b0;
    #1 reset_checks("por");
    step();
    step();
    reset_n = 1'b1;
    step();
    reset_checks("post_por");

    // Two-note sequence, with start-latency detail.
    wr(0, ent(0, 2, 5, 'h123));
    wr(1, ent(1, 1, 9, 'h040));
    wr(2, ent(0, 1, 1, 'h001));
    wr(3, ent(0, 1, 2, 'h002));
    do_start();
    chk("lat_busy_e1", 32'(busy), 1);
    chk("lat_strobe_e1", 32'(note_strobe), 0);
    step();
    chk("lat_strobe_e2", 32'(note_strobe), 0);
    step();
    chk("lat_strobe_e3", 32'(note_strobe), 1);
    build(0, 0, 16);
    play_check();

    // Loop, then clear loop_en to finish after the next entry 1.
    loop_en = 1'b1;
    do_start();
    build(1, 0, 5);
    play_check();
    loop_en = 1'b0;
    build(0, 1, 16);
    play_check();

    // Asynchronous reset in the middle of a note.
    do_start();
    build(0, 0, 1);
    play_check();
    step();
    step();
    #2 reset_n = 1'b0;
    #1 reset_checks("midplay_rst");
    step();
    reset_n = 1'b1;
    step();
    do_start();
    build(0, 0, 16);
    play_check();

    // Stop marker in entry 0 with looping enabled.
    loop_en = 1'b1;
    wr(0, ent(0, 0, 3, 'h555));
    do_start();
    chk("marker_strobe_e1", 32'(note_strobe), 0);
    chk("marker_done_e1", 32'(done), 0);
    step();
    chk("marker_strobe_e2", 32'(note_strobe), 0);
    chk("marker_done_e2", 32'(done), 0);
    step();
    chk("marker_done_e3", 32'(done), 1);
    chk("marker_strobe_e3", 32'(note_strobe), 0);
    chk("marker_busy_e3", 32'(busy), 0);
    chk("marker_vol_e3", 32'(snd_vol), 0);
    step();
    chk("marker_done_pulse", 32'(done), 0);

    // Stop marker in entry 2 while looping: 0,1,0,1.
    wr(0, ent(0, 1, 4, 'h210));
    wr(1, ent(0, 2, 6, 'h321));
    wr(2, ent(0, 0, 7, 'h777));
    do_start();
    build(1, 0, 4);
    play_check();
    do_stop(1'b0);
    loop_en = 1'b0;

    // start and stop together during PLAY: stop wins.
    wr(0, ent(0, 2, 5, 'h123));
    wr(1, ent(1, 1, 9, 'h040));
    do_start();
    build(0, 0, 1);
    play_check();
    step();
    do_stop(1'b1);

    // start during entry 1 restarts at entry 0 two edges later.
    do_start();
    build(0, 0, 2);
    play_check();
    step();
    do_start();
    chk("restart_busy", 32'(busy), 1);
    step();
    step();
    chk("restart_strobe", 32'(note_strobe), 1);
    chk("restart_idx", 32'(note_idx), 0);
    chk("restart_vol", 32'(snd_vol), 5);
    exp_period = 'h123;
    exp_nidx   = 0;
    do_stop(1'b0);

    // Rewrite entry 1 while entry 0 plays: the new data is played.
    do_start();
    build(0, 0, 1);
    play_check();
    wr(1, ent(1, 1, 7, 'h3A5));
    build(0, 1, 16);
    play_check();

    // No end flags anywhere: note_idx wraps 3 -> 0.
    wr(0, ent(0, 1, 1, 'h101));
    wr(1, ent(0, 1, 2, 'h202));
    wr(2, ent(0, 1, 3, 'h303));
    wr(3, ent(0, 1, 4, 'h404));
    do_start();
    build(0, 0, 6);
    play_check();
    do_stop(1'b0);

    // Randomized tables and loop setting.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NENT; i++) begin
        wr(i, ent(($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 4095))));
      end
      lp      = int'($urandom_range(0, 1));
      loop_en = lp[0];
      do_start();
      build(lp[0], 0, 8);
      play_check();
      do_stop(1'b0);
    end
    loop_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snd_sequencer.md
# snd_sequencer

Note sequencer for the I2S audio path. Holds a small writable note table and, once started, steps through it, driving the volume and period inputs of the sound generator for a programmed number of sample frames per note. Sits between the CPU-side register interface and the sound generator/I2S serializer, in the same clock domain as the generator's control inputs. Frame timing comes in from the I2S side as a one-cycle `tick` strobe.

## Interface
Parameters:
- `ADDR_W`, default 4: note table address width; the table holds 2^ADDR_W entries.
- `TICKS_PER_UNIT`, default 122: number of `tick` strobes per duration unit, about 10 ms at a 12.2 kHz frame rate. Legal range is 1..65535.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for the note table.
- `wr_addr`  in  ADDR_W  table entry to write.
- `wr_data`  in  25  entry contents: [24] `end`, [23:16] `dur`, [15:12] `vol`, [11:0] `period`.
- `start`  in  1  one-cycle pulse: play the table from entry 0.
- `stop`  in  1  one-cycle pulse: abort playback and silence the output.
- `loop_en`  in  1  level: after an end condition, restart at entry 0 instead of finishing.
- `tick`  in  1  one-cycle pulse per audio frame.
- `snd_vol`  out  4  volume to the sound generator.
- `snd_period`  out  12  period to the sound generator.
- `busy`  out  1  high while not in IDLE.
- `note_idx`  out  ADDR_W  index of the entry currently loaded.
- `note_strobe`  out  1  one-cycle pulse when a new note is applied.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- **Note table.** 2^ADDR_W × 25-bit RAM with one write port and a synchronous read (1-cycle latency).
  - Contents are not reset.
  - Writes are accepted in any state.
  - If a write and a read hit the same address in the same cycle, the read returns the old data.
- **State machine.** States are IDLE, FETCH, LOAD, PLAY.
  - **IDLE.** On `start`, set idx=0 and go to FETCH.
  - **FETCH.** Present idx to the RAM; go to LOAD.
  - **LOAD, `dur`≠0.** Register `vol`, `period`, idx, and dur_rem=`dur`. Clear the tick prescaler. Pulse `note_strobe`. Go to PLAY.
  - **LOAD, `dur`=0 (stop marker).** Nothing is played.
    - If `loop_en`=1 and idx≠0: set idx=0 and go to FETCH.
    - Otherwise: set `snd_vol`=0, pulse `done`, go to IDLE. This branch prevents an infinite loop when entry 0 is itself a stop marker.
  - **PLAY, counting.** On each `tick`, the prescaler increments. When it reaches TICKS_PER_UNIT−1, it wraps to 0 and dur_rem decrements.
  - **PLAY, note expiry.** When dur_rem would go from 1 to 0:
    - If entry `end`=0: idx=idx+1, wrapping modulo 2^ADDR_W, then FETCH.
    - If entry `end`=1 and `loop_en`=1: idx=0, then FETCH.
    - If entry `end`=1 and `loop_en`=0: `snd_vol`=0, pulse `done`, IDLE.
- **Held outputs.** During FETCH and LOAD between notes, `snd_vol` and `snd_period` hold the previous note. There is no silence gap.
- **`stop`.** From any state: IDLE on the next edge, `snd_vol`=0, no `done` pulse. `snd_period` and `note_idx` hold their values.
- **`start` while busy.** Restart at entry 0 (go to FETCH); no `done` pulse.
- **Simultaneous `start` and `stop`.** `stop` wins.
- **`tick` outside PLAY.** Ignored, including a `tick` in the same cycle as LOAD.
- **Resulting note length.** Every note lasts exactly `dur`×TICKS_PER_UNIT ticks.
- **`loop_en`.** Sampled only at end decisions.

## Timing
- **Reset values.** While reset is asserted: `snd_vol`=0, `snd_period`=0, `busy`=0, `note_idx`=0, `note_strobe`=0, `done`=0, state=IDLE.
- **Reset mid-playback.** Takes effect immediately (asynchronous).
- **Start latency.** Let edge E be the edge that samples `start`. The state is FETCH after E and LOAD after E+1. New `snd_vol`/`snd_period`/`note_idx` are visible after E+2, with `note_strobe`=1 for that cycle.
- **`busy`.** High from the cycle after E until the state returns to IDLE.
- **Note-to-note gap.** Two clocks (FETCH, LOAD). This gap must be much shorter than the tick period, and it does not shift the tick phase.
- **`done`.** Registered; high for exactly the cycle following the LOAD or PLAY decision. `busy` is 0 in that same cycle.
- **Registered outputs.** All outputs are registered; none is combinational from an input.

## Test plan
All scenarios use TICKS_PER_UNIT=4 and `tick` every 8 clocks.
1. **Reset.** Assert `reset_n`=0 mid-PLAY → all outputs are zero immediately and `busy`=0; after release, `start` plays from entry 0.
2. **Two-note sequence.** Entry0={end=0, dur=2, vol=5, period=0x123}, entry1={end=1, dur=1, vol=9, period=0x040}, `start` → `note_strobe` two edges after `start`, outputs 5/0x123 for 8 ticks, then 9/0x040 for 4 ticks, then `snd_vol`=0, `done` pulse, `busy`=0.
3. **Loop.** Same table with `loop_en`=1 → entry 0 reloads after entry 1's 4 ticks and `done` never pulses. Clear `loop_en` → finishes at the next end of entry 1.
4. **Stop marker.** Entry0 dur=0 with `loop_en`=1 → `done` within 3 clocks of `start` and no `note_strobe`. Entry2 dur=0, entries 0–1 valid, `loop_en`=1 → playback cycles 0,1,0,1.
5. **Control collisions.**
   - `stop` and `start` in the same cycle during PLAY → IDLE, `snd_vol`=0, no `done`.
   - `start` during entry 1 → `note_idx`=0 two edges later.
6. **Table edge cases.**
   - Write to entry 1 while entry 0 plays → the new entry-1 data is played.
   - With ADDR_W=2 and no `end` flag in any entry → `note_idx` wraps 3→0.
